// File: rtl/decode_stage_if.sv
// Decode-stage bus bundle: IF/ID inputs, writeback port, flush, hazard-unit
// source indices and the registered ID/EX outputs.
interface decode_stage_if;
  // IF/ID register contents
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;

  // writeback port into the register file
  logic        RegWriteW;
  logic [4:0]  RdW;
  logic [31:0] ResultW;

  // bubble request for ID/EX
  logic        ID_flush;

  // combinational source indices for the hazard unit
  logic [4:0]  Rs1D;
  logic [4:0]  Rs2D;

  // ID/EX register outputs
  logic [31:0] RD1E;
  logic [31:0] RD2E;
  logic [31:0] ImmExtE;
  logic [31:0] PCE;
  logic [31:0] PCPlus4E;
  logic [4:0]  Rs1E;
  logic [4:0]  Rs2E;
  logic [4:0]  RdE;
  logic [2:0]  Funct3E;
  logic [2:0]  ALUControlE;
  logic [1:0]  ResultSrcE;
  logic        RegWriteE;
  logic        MemWriteE;
  logic        BranchE;
  logic        JumpE;
  logic        ALUSrcE;

  // pipeline / environment side: drives the decode stage inputs
  modport master (
    output InstrD, PCD, PCPlus4D,
    output RegWriteW, RdW, ResultW,
    output ID_flush,
    input  Rs1D, Rs2D,
    input  RD1E, RD2E, ImmExtE, PCE, PCPlus4E,
    input  Rs1E, Rs2E, RdE, Funct3E, ALUControlE, ResultSrcE,
    input  RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE
  );

  // decode stage side
  modport slave (
    input  InstrD, PCD, PCPlus4D,
    input  RegWriteW, RdW, ResultW,
    input  ID_flush,
    output Rs1D, Rs2D,
    output RD1E, RD2E, ImmExtE, PCE, PCPlus4E,
    output Rs1E, Rs2E, RdE, Funct3E, ALUControlE, ResultSrcE,
    output RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE
  );
endinterface

// File: rtl/decode_stage.sv
// RV32 decode stage: 32x32 register file with writeback bypass, immediate
// generation, main/ALU control decode and the ID/EX pipeline register.
module decode_stage (
  input  logic           clk,
  input  logic           rst,
  decode_stage_if.slave  dif
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;
  logic        wb_en;

  assign instr  = dif.InstrD;
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign wb_en  = dif.RegWriteW && (dif.RdW != 5'd0);

  // hazard-unit indices follow the instruction even while in reset
  assign dif.Rs1D = rs1;
  assign dif.Rs2D = rs2;

  // ---------------------------------------------------------------------
  // register file
  // ---------------------------------------------------------------------
  logic [31:0] regs_q [32];

  // writeback into the array; x0 is never written so it stays zero
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= 32'd0;
      end
    end else if (wb_en) begin
      regs_q[dif.RdW] <= dif.ResultW;
    end
  end

  logic [31:0] rd1_d, rd2_d;

  // source reads; a same-cycle writeback to the same index is forwarded
  always_comb begin
    rd1_d = 32'd0;
    rd2_d = 32'd0;
    if (rs1 != 5'd0) begin
      if (wb_en && (dif.RdW == rs1)) rd1_d = dif.ResultW;
      else                           rd1_d = regs_q[rs1];
    end
    if (rs2 != 5'd0) begin
      if (wb_en && (dif.RdW == rs2)) rd2_d = dif.ResultW;
      else                           rd2_d = regs_q[rs2];
    end
  end

  // ---------------------------------------------------------------------
  // immediate generation
  // ---------------------------------------------------------------------
  logic [31:0] imm_d;

  // sign-extended immediate selected by instruction format
  always_comb begin
    imm_d = 32'd0;
    case (opcode)
      OP_LOAD, OP_IALU: imm_d = {{20{instr[31]}}, instr[31:20]};
      OP_STORE:         imm_d = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OP_BRANCH:        imm_d = {{19{instr[31]}}, instr[31], instr[7],
                                 instr[30:25], instr[11:8], 1'b0};
      OP_JAL:           imm_d = {{11{instr[31]}}, instr[31], instr[19:12],
                                 instr[20], instr[30:21], 1'b0};
      default:          imm_d = 32'd0;
    endcase
  end

  // ---------------------------------------------------------------------
  // control decode
  // ---------------------------------------------------------------------
  logic       reg_write_d, mem_write_d, branch_d, jump_d, alu_src_d;
  logic [1:0] result_src_d;
  logic       alu_from_funct3;

  // main control; unknown opcodes (including InstrD=0) decode as a bubble
  always_comb begin
    reg_write_d     = 1'b0;
    result_src_d    = 2'b00;
    mem_write_d     = 1'b0;
    branch_d        = 1'b0;
    jump_d          = 1'b0;
    alu_src_d       = 1'b0;
    alu_from_funct3 = 1'b0;
    case (opcode)
      OP_LOAD: begin
        reg_write_d  = 1'b1;
        result_src_d = 2'b01;
        alu_src_d    = 1'b1;
      end
      OP_STORE: begin
        mem_write_d = 1'b1;
        alu_src_d   = 1'b1;
      end
      OP_RTYPE: begin
        reg_write_d     = 1'b1;
        alu_from_funct3 = 1'b1;
      end
      OP_IALU: begin
        reg_write_d     = 1'b1;
        alu_src_d       = 1'b1;
        alu_from_funct3 = 1'b1;
      end
      OP_BRANCH: begin
        branch_d = 1'b1;
      end
      OP_JAL: begin
        reg_write_d  = 1'b1;
        result_src_d = 2'b10;
        jump_d       = 1'b1;
      end
      default: ;
    endcase
  end

  logic [2:0] alu_ctrl_d;

  // ALU operation: fixed for memory/jump/branch, funct3-driven for ALU ops;
  // only register-register ops honour funct7[5] as subtract
  always_comb begin
    alu_ctrl_d = ALU_ADD;
    if (opcode == OP_BRANCH) begin
      alu_ctrl_d = ALU_SUB;
    end else if (alu_from_funct3) begin
      case (funct3)
        3'b000:  alu_ctrl_d = ((opcode == OP_RTYPE) && instr[30]) ? ALU_SUB : ALU_ADD;
        3'b010:  alu_ctrl_d = ALU_SLT;
        3'b110:  alu_ctrl_d = ALU_OR;
        3'b111:  alu_ctrl_d = ALU_AND;
        default: alu_ctrl_d = ALU_ADD;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // ID/EX pipeline register
  // ---------------------------------------------------------------------
  logic [31:0] rd1_q, rd2_q, imm_q, pc_q, pc_plus4_q;
  logic [4:0]  rs1_q, rs2_q, rd_q;
  logic [2:0]  funct3_q, alu_ctrl_q;
  logic [1:0]  result_src_q;
  logic        reg_write_q, mem_write_q, branch_q, jump_q, alu_src_q;

  // capture decode each cycle; reset beats flush, flush inserts a zero bubble
  always_ff @(posedge clk) begin
    if (!rst || dif.ID_flush) begin
      rd1_q        <= 32'd0;
      rd2_q        <= 32'd0;
      imm_q        <= 32'd0;
      pc_q         <= 32'd0;
      pc_plus4_q   <= 32'd0;
      rs1_q        <= 5'd0;
      rs2_q        <= 5'd0;
      rd_q         <= 5'd0;
      funct3_q     <= 3'd0;
      alu_ctrl_q   <= 3'd0;
      result_src_q <= 2'd0;
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      branch_q     <= 1'b0;
      jump_q       <= 1'b0;
      alu_src_q    <= 1'b0;
    end else begin
      rd1_q        <= rd1_d;
      rd2_q        <= rd2_d;
      imm_q        <= imm_d;
      pc_q         <= dif.PCD;
      pc_plus4_q   <= dif.PCPlus4D;
      rs1_q        <= rs1;
      rs2_q        <= rs2;
      rd_q         <= rd;
      funct3_q     <= funct3;
      alu_ctrl_q   <= alu_ctrl_d;
      result_src_q <= result_src_d;
      reg_write_q  <= reg_write_d;
      mem_write_q  <= mem_write_d;
      branch_q     <= branch_d;
      jump_q       <= jump_d;
      alu_src_q    <= alu_src_d;
    end
  end

  assign dif.RD1E        = rd1_q;
  assign dif.RD2E        = rd2_q;
  assign dif.ImmExtE     = imm_q;
  assign dif.PCE         = pc_q;
  assign dif.PCPlus4E    = pc_plus4_q;
  assign dif.Rs1E        = rs1_q;
  assign dif.Rs2E        = rs2_q;
  assign dif.RdE         = rd_q;
  assign dif.Funct3E     = funct3_q;
  assign dif.ALUControlE = alu_ctrl_q;
  assign dif.ResultSrcE  = result_src_q;
  assign dif.RegWriteE   = reg_write_q;
  assign dif.MemWriteE   = mem_write_q;
  assign dif.BranchE     = branch_q;
  assign dif.JumpE       = jump_q;
  assign dif.ALUSrcE     = alu_src_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: each step drives one decode cycle, pushes
// the expected ID/EX contents to a scoreboard queue and checks them after the edge.
module tb_decode_stage;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  decode_stage_if dif ();

  decode_stage u_dut (
    .clk (clk),
    .rst (rst),
    .dif (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] pcp4;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [2:0]  aluc;
    logic [1:0]  rsrc;
    logic        regw;
    logic        memw;
    logic        br;
    logic        jmp;
    logic        alusrc;
  } exp_t;

  exp_t exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  function automatic exp_t ctl(input logic regw, input logic [1:0] rsrc, input logic memw,
                               input logic br, input logic jmp, input logic alusrc,
                               input logic [2:0] aluc);
    exp_t e;
    e        = '0;
    e.regw   = regw;
    e.rsrc   = rsrc;
    e.memw   = memw;
    e.br     = br;
    e.jmp    = jmp;
    e.alusrc = alusrc;
    e.aluc   = aluc;
    return e;
  endfunction

  // one decode cycle: drive inputs, queue the expectation, check after the edge
  task automatic step(input string name, input logic [31:0] instr, input logic [31:0] pc,
                      input logic rst_v, input logic flush, input logic wb_en,
                      input logic [4:0] wb_rd, input logic [31:0] wb_val, input exp_t ein);
    exp_t e;
    exp_t got;
    @(negedge clk);
    rst           = rst_v;
    dif.InstrD    = instr;
    dif.PCD       = pc;
    dif.PCPlus4D  = pc + 32'd4;
    dif.ID_flush  = flush;
    dif.RegWriteW = wb_en;
    dif.RdW       = wb_rd;
    dif.ResultW   = wb_val;
    if (!rst_v || flush) begin
      e = '0;
    end else begin
      e      = ein;
      e.pc   = pc;
      e.pcp4 = pc + 32'd4;
      e.rs1  = instr[19:15];
      e.rs2  = instr[24:20];
      e.rd   = instr[11:7];
      e.f3   = instr[14:12];
    end
    exp_q.push_back(e);
    #1;
    chk($sformatf("%s.Rs1D", name), {27'd0, dif.Rs1D}, {27'd0, instr[19:15]});
    chk($sformatf("%s.Rs2D", name), {27'd0, dif.Rs2D}, {27'd0, instr[24:20]});
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    chk($sformatf("%s.RD1E", name),        dif.RD1E,     got.rd1);
    chk($sformatf("%s.RD2E", name),        dif.RD2E,     got.rd2);
    chk($sformatf("%s.ImmExtE", name),     dif.ImmExtE,  got.imm);
    chk($sformatf("%s.PCE", name),         dif.PCE,      got.pc);
    chk($sformatf("%s.PCPlus4E", name),    dif.PCPlus4E, got.pcp4);
    chk($sformatf("%s.Rs1E", name),        {27'd0, dif.Rs1E},        {27'd0, got.rs1});
    chk($sformatf("%s.Rs2E", name),        {27'd0, dif.Rs2E},        {27'd0, got.rs2});
    chk($sformatf("%s.RdE", name),         {27'd0, dif.RdE},         {27'd0, got.rd});
    chk($sformatf("%s.Funct3E", name),     {29'd0, dif.Funct3E},     {29'd0, got.f3});
    chk($sformatf("%s.ALUControlE", name), {29'd0, dif.ALUControlE}, {29'd0, got.aluc});
    chk($sformatf("%s.ResultSrcE", name),  {30'd0, dif.ResultSrcE},  {30'd0, got.rsrc});
    chk($sformatf("%s.ctl", name),
        {27'd0, dif.RegWriteE, dif.MemWriteE, dif.BranchE, dif.JumpE, dif.ALUSrcE},
        {27'd0, got.regw, got.memw, got.br, got.jmp, got.alusrc});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t        e;
    logic [31:0] ins;
    checks        = 0;
    errors        = 0;
    rst           = 1'b0;
    dif.InstrD    = 32'd0;
    dif.PCD       = 32'd0;
    dif.PCPlus4D  = 32'd0;
    dif.ID_flush  = 1'b0;
    dif.RegWriteW = 1'b0;
    dif.RdW       = 5'd0;
    dif.ResultW   = 32'd0;

    // reset for two edges with live decode and a writeback pending
    e = '0;
    step("rst0", 32'h05CD1A63, 32'h40, 1'b0, 1'b0, 1'b1, 5'd3, 32'hDEAD_BEEF, e);
    step("rst1", 32'h00592023, 32'h44, 1'b0, 1'b0, 1'b1, 5'd3, 32'hDEAD_BEEF, e);

    // fetch-flush instruction decodes as a bubble
    e = '0;
    step("nop0", 32'h0000_0000, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, e);

    // every register reads zero after reset (add x0, xi, xi)
    for (int i = 1; i < 32; i++) begin
      ins = {7'd0, 5'(i), 5'(i), 3'b000, 5'd0, 7'b0110011};
      e   = ctl(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
      step($sformatf("rdz%0d", i), ins, 32'h80, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, e);
    end

    // addi x18, x0, 24
    e = ctl(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000);
    e.imm = 32'd24;
    step("addi", 32'h01800913, 32'h100, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, e);

    // writeback x18 = 24 alongside a bubble
    e = '0;
    step("wb18", 32'h0000_0000, 32'h104, 1'b1, 1'b0, 1'b1, 5'd18, 32'd24, e);

    // sw x5,0(x18) with x5 <- 2 written in the same cycle
    e = ctl(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000);
    e.rd1 = 32'd24;
    e.rd2 = 32'd2;
    step("sw_byp", 32'h00592023, 32'h108, 1'b1, 1'b0, 1'b1, 5'd5, 32'd2, e);

    // sub x7, x18, x5 reads both values from the array
    e = ctl(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001);
    e.rd1 = 32'd24;
    e.rd2 = 32'd2;
    step("sub", 32'h405903B3, 32'h10C, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, e);

    // bne x26, x28, +84
    e = ctl(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 3'b001);
    e.imm = 32'd84;
    step("bne", 32'h05CD1A63, 32'h110, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, e);

    // lw x9, 8(x18): flushed first, then captured
    e = '0;
    step("flush", 32'h00892483, 32'h114, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0, e);
    e = ctl(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000);
    e.imm = 32'd8;
    e.rd1 = 32'd24;
    step("lw", 32'h00892483, 32'h114, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, e);

    // write to x0 is neither forwarded nor stored (addi x1, x0, 0)
    e = ctl(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000);
    step("x0_byp", 32'h00000093, 32'h118, 1'b1, 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, e);
    step("x0_rd", 32'h00000093, 32'h11C, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, e);

    // jal x1, -4
    e = ctl(1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000);
    e.imm = 32'hFFFF_FFFC;
    step("jal", 32'hFFDFF0EF, 32'h120, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, e);

    // ori x3, x0, -1
    e = ctl(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 3'b011);
    e.imm = 32'hFFFF_FFFF;
    step("ori", 32'hFFF06193, 32'h124, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, e);

    // addi x4, x0, 0x400: bit30 set must stay add for I-type
    e = ctl(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000);
    e.imm = 32'h0000_0400;
    step("addi_b30", 32'h40000213, 32'h128, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, e);

    // and x5, x1, x2 with x1 <- 0xF0 forwarded
    e = ctl(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010);
    e.rd1 = 32'h0000_00F0;
    step("and", 32'h0020F2B3, 32'h12C, 1'b1, 1'b0, 1'b1, 5'd1, 32'h0000_00F0, e);

    // slt x6, x1, x2 with x2 <- 0x55 forwarded, x1 from array
    e = ctl(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'b101);
    e.rd1 = 32'h0000_00F0;
    e.rd2 = 32'h0000_0055;
    step("slt", 32'h0020A333, 32'h130, 1'b1, 1'b0, 1'b1, 5'd2, 32'h0000_0055, e);

    // lui is outside the decoded set: controls and immediate stay zero
    e = '0;
    step("lui", 32'h000012B7, 32'h134, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, e);

    // mid-stream reset discards the decode and clears the array
    e = '0;
    step("rst_mid", 32'h405903B3, 32'h138, 1'b0, 1'b0, 1'b1, 5'd7, 32'h77, e);
    e = ctl(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001);
    step("post_rst", 32'h405903B3, 32'h13C, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, e);
    e = ctl(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'b101);
    step("post_rst2", 32'h0020A333, 32'h140, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, e);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
